// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stage indices, FSM encoding and boolean macros for pipe_ctrl
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package pipe_ctrl_pkg;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENTER = 2'd2
  } pipe_state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/redirect bundle between pipeline stages and pipe_ctrl
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int XLEN       = 32
);
  logic                  br_taken_i;
  logic [XLEN-1:0]       br_target_i;
  logic                  load_use_i;
  logic                  mc_busy_i;
  logic                  mem_busy_i;
  logic                  hold_flag_clint_i;
  logic                  int_req_i;
  logic [XLEN-1:0]       int_target_i;
  logic [XLEN-1:0]       if_pc_i;
  logic [NUM_STAGES-1:0] hold_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  redirect_o;
  logic [XLEN-1:0]       redirect_pc_o;
  logic                  int_ack_o;
  logic [XLEN-1:0]       int_epc_o;
  logic                  drain_o;

  modport master (
    output br_taken_i, br_target_i, load_use_i, mc_busy_i, mem_busy_i,
           hold_flag_clint_i, int_req_i, int_target_i, if_pc_i,
    input  hold_o, flush_o, redirect_o, redirect_pc_o, int_ack_o, int_epc_o, drain_o
  );

  modport slave (
    input  br_taken_i, br_target_i, load_use_i, mc_busy_i, mem_busy_i,
           hold_flag_clint_i, int_req_i, int_target_i, if_pc_i,
    output hold_o, flush_o, redirect_o, redirect_pc_o, int_ack_o, int_epc_o, drain_o
  );
endinterface

// File: rtl/pipe_stall_vec.sv
// rtl/pipe_stall_vec.sv - maps a stalling stage index to hold/flush vectors
// Stall at k holds stages 0..k and bubbles the register feeding stage k+1.
module pipe_stall_vec #(
  parameter int NUM_STAGES = 5,
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                  en,
  input  logic [IDX_W-1:0]      stage,
  output logic [NUM_STAGES-1:0] hold,
  output logic [NUM_STAGES-1:0] flush
);
  always_comb begin
    hold  = '0;
    flush = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      hold[i]  = en && (i <= int'(stage));
      flush[i] = en && (i == int'(stage) + 1);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - merges stage stalls, EX redirects and CLINT hold into hold/flush
// vectors, and sequences interrupt entry (drain, capture epc, redirect to trap vector).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int XLEN       = 32,
  parameter int ID_STAGE   = STG_ID,
  parameter int EX_STAGE   = STG_EX,
  parameter int MEM_STAGE  = STG_MEM
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [NUM_STAGES-1:0] ENTER_FLUSH = {{(NUM_STAGES-1){1'b1}}, 1'b0};
  localparam logic [NUM_STAGES-1:0] BR_FLUSH    = NUM_STAGES'((1 << (EX_STAGE + 1)) - 2);

  pipe_state_t           state;
  logic [IDX_W-1:0]      cnt;
  logic [XLEN-1:0]       epc;
  logic                  drain_q;

  logic                  stall_en;
  logic [IDX_W-1:0]      stall_idx;
  logic [NUM_STAGES-1:0] sv_hold;
  logic [NUM_STAGES-1:0] sv_flush;
  logic [NUM_STAGES-1:0] hold_c;
  logic [NUM_STAGES-1:0] flush_c;
  logic                  redirect_c;
  logic [XLEN-1:0]       redirect_pc_c;
  logic                  ack_c;
  logic                  br_fire;
  logic                  cnt_en;

  pipe_stall_vec #(.NUM_STAGES(NUM_STAGES), .IDX_W(IDX_W)) u_stall_vec (
    .en    (stall_en),
    .stage (stall_idx),
    .hold  (sv_hold),
    .flush (sv_flush)
  );

  always_comb begin
    stall_en      = 1'b0;
    stall_idx     = '0;
    hold_c        = '0;
    flush_c       = '0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    ack_c         = 1'b0;
    br_fire       = 1'b0;
    if (rst_n) begin
      if (bus.hold_flag_clint_i) begin
        hold_c = '1;
      end else if (state == ST_ENTER) begin
        redirect_c    = 1'b1;
        redirect_pc_c = bus.int_target_i;
        ack_c         = 1'b1;
        flush_c       = ENTER_FLUSH;
      end else if (bus.mem_busy_i) begin
        stall_en  = 1'b1;
        stall_idx = IDX_W'(MEM_STAGE);
      end else if (bus.mc_busy_i) begin
        stall_en  = 1'b1;
        stall_idx = IDX_W'(EX_STAGE);
      end else if (bus.br_taken_i) begin
        br_fire       = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = bus.br_target_i;
        flush_c       = BR_FLUSH;
        // Keep IF frozen while draining so the redirected fetch does not slip in.
        hold_c[0]     = (state == ST_DRAIN);
      end else if (bus.load_use_i) begin
        stall_en  = 1'b1;
        stall_idx = IDX_W'(ID_STAGE);
      end else if (state == ST_DRAIN) begin
        stall_en  = 1'b1;
        stall_idx = '0;
      end
    end
  end

  assign cnt_en = !bus.mem_busy_i && !bus.mc_busy_i && !bus.load_use_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      epc     <= '0;
      drain_q <= `FALSE;
    end else if (!bus.hold_flag_clint_i) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.int_req_i) begin
            state   <= ST_DRAIN;
            cnt     <= IDX_W'(NUM_STAGES - 1);
            epc     <= br_fire ? bus.br_target_i : bus.if_pc_i;
            drain_q <= `TRUE;
          end
        end
        ST_DRAIN: begin
          // A taken branch in the shadow means the true return point is its target.
          if (br_fire) epc <= bus.br_target_i;
          if (cnt_en) begin
            cnt <= cnt - IDX_W'(1);
            if (cnt == IDX_W'(1)) state <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          state   <= ST_IDLE;
          drain_q <= `FALSE;
        end
        default: begin
          state   <= ST_IDLE;
          drain_q <= `FALSE;
        end
      endcase
    end
  end

  assign bus.hold_o        = hold_c | sv_hold;
  assign bus.flush_o       = flush_c | sv_flush;
  assign bus.redirect_o    = redirect_c;
  assign bus.redirect_pc_o = redirect_pc_c;
  assign bus.int_ack_o     = ack_c;
  assign bus.int_epc_o     = epc;
  assign bus.drain_o       = drain_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  localparam int N  = 5;
  localparam int XL = 32;
  localparam int OW = 2 * N + 2 * XL + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  int          m_left  = 0;
  bit          m_enter = 1'b0;
  logic [XL-1:0] m_epc = '0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.NUM_STAGES(N), .XLEN(XL)) bus ();

  pipe_ctrl #(.NUM_STAGES(N), .XLEN(XL), .ID_STAGE(1), .EX_STAGE(2), .MEM_STAGE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [OW-1:0] observed();
    return {bus.hold_o, bus.flush_o, bus.redirect_o, bus.redirect_pc_o,
            bus.int_ack_o, bus.int_epc_o, bus.drain_o};
  endfunction

  function automatic logic [N-1:0] stall_hold(int k);
    return N'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [N-1:0] stall_flush(int k);
    return N'(1 << (k + 1));
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0]  h;
    logic [N-1:0]  f;
    logic          r;
    logic [XL-1:0] rp;
    logic          a;
    h = '0; f = '0; r = 1'b0; rp = '0; a = 1'b0;
    if (rst_n) begin
      if (bus.hold_flag_clint_i) h = '1;
      else if (m_enter) begin
        r = 1'b1; rp = bus.int_target_i; a = 1'b1; f = N'((1 << N) - 2);
      end else if (bus.mem_busy_i) begin
        h = stall_hold(3); f = stall_flush(3);
      end else if (bus.mc_busy_i) begin
        h = stall_hold(2); f = stall_flush(2);
      end else if (bus.br_taken_i) begin
        r = 1'b1; rp = bus.br_target_i; f = N'((1 << 3) - 2);
        h = (m_left > 0) ? N'(1) : N'(0);
      end else if (bus.load_use_i) begin
        h = stall_hold(1); f = stall_flush(1);
      end else if (m_left > 0) begin
        h = stall_hold(0); f = stall_flush(0);
      end
    end
    return {h, f, r, rp, a, (rst_n ? m_epc : {XL{1'b0}}),
            (rst_n && (m_left > 0 || m_enter))};
  endfunction

  task automatic model_step();
    bit br;
    if (!rst_n) begin
      m_left = 0; m_enter = 1'b0; m_epc = '0;
    end else if (!bus.hold_flag_clint_i) begin
      br = !m_enter && !bus.mem_busy_i && !bus.mc_busy_i && bus.br_taken_i;
      if (m_enter) m_enter = 1'b0;
      else if (m_left > 0) begin
        if (br) m_epc = bus.br_target_i;
        if (!bus.mem_busy_i && !bus.mc_busy_i && !bus.load_use_i) begin
          m_left--;
          m_enter = (m_left == 0);
        end
      end else if (bus.int_req_i) begin
        m_left = N - 1;
        m_epc  = br ? bus.br_target_i : bus.if_pc_i;
      end
    end
  endtask

  task automatic clr();
    bus.br_taken_i = 1'b0; bus.br_target_i = '0; bus.load_use_i = 1'b0;
    bus.mc_busy_i = 1'b0; bus.mem_busy_i = 1'b0; bus.hold_flag_clint_i = 1'b0;
    bus.int_req_i = 1'b0; bus.int_target_i = 32'h200; bus.if_pc_i = 32'h100;
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0; bus.br_taken_i = 1'b1; bus.mem_busy_i = 1'b1; bus.br_target_i = 32'h80;
    #2;
    checks++;
    if (observed() !== '0) $display("FAIL reset_outputs actual=%h required=0", observed());
    else passed++;
    @(negedge clk); rst_n = 1'b1; clr(); #2;
    checks++;
    if ({bus.hold_o, bus.redirect_o} !== 6'b0)
      $display("FAIL reset_release actual=%b required=000000", {bus.hold_o, bus.redirect_o});
    else passed++;
  endtask

  task automatic test_branch();
    logic [42:0] got;
    logic [42:0] req;
    req = {1'b1, 32'h80, 5'b00110, 5'b00000};
    @(negedge clk); clr(); bus.br_taken_i = 1'b1; bus.br_target_i = 32'h80; #2;
    got = {bus.redirect_o, bus.redirect_pc_o, bus.flush_o, bus.hold_o};
    checks++;
    if (got !== req) $display("FAIL branch actual=%h required=%h", got, req); else passed++;
    bus.load_use_i = 1'b1; #1;
    got = {bus.redirect_o, bus.redirect_pc_o, bus.flush_o, bus.hold_o};
    checks++;
    if (got !== req) $display("FAIL branch_over_load_use actual=%h required=%h", got, req); else passed++;
  endtask

  task automatic test_stall_priority();
    logic [10:0] got;
    @(negedge clk); clr(); bus.mc_busy_i = 1'b1; bus.br_taken_i = 1'b1; bus.br_target_i = 32'h44; #2;
    got = {bus.hold_o, bus.flush_o, bus.redirect_o};
    checks++;
    if (got !== {5'b00111, 5'b01000, 1'b0}) $display("FAIL mc_stall actual=%b required=%b", got, {5'b00111, 5'b01000, 1'b0});
    else passed++;
    @(negedge clk); clr(); bus.mem_busy_i = 1'b1; bus.mc_busy_i = 1'b1; #2;
    got = {bus.hold_o, bus.flush_o, bus.redirect_o};
    checks++;
    if (got !== {5'b01111, 5'b10000, 1'b0}) $display("FAIL mem_stall actual=%b required=%b", got, {5'b01111, 5'b10000, 1'b0});
    else passed++;
    @(negedge clk); clr(); bus.load_use_i = 1'b1; #2;
    got = {bus.hold_o, bus.flush_o, bus.redirect_o};
    checks++;
    if (got !== {5'b00011, 5'b00100, 1'b0}) $display("FAIL load_use_stall actual=%b required=%b", got, {5'b00011, 5'b00100, 1'b0});
    else passed++;
  endtask

  task automatic test_interrupt();
    logic [11:0] dgot;
    logic [76:0] egot;
    logic [76:0] ereq;
    @(negedge clk); clr(); bus.int_req_i = 1'b1; #2;
    checks++;
    if ({bus.drain_o, bus.hold_o} !== 6'b0) $display("FAIL int_idle_cycle actual=%b required=000000", {bus.drain_o, bus.hold_o});
    else passed++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); bus.if_pc_i = 32'h140; #2;
      dgot = {bus.hold_o, bus.flush_o, bus.drain_o, bus.int_ack_o};
      checks++;
      if (dgot !== {5'b00001, 5'b00010, 1'b1, 1'b0})
        $display("FAIL int_drain c=%0d actual=%b required=%b", c, dgot, {5'b00001, 5'b00010, 1'b1, 1'b0});
      else passed++;
    end
    @(negedge clk); #2;
    egot = {bus.redirect_o, bus.redirect_pc_o, bus.int_ack_o, bus.int_epc_o, bus.flush_o, bus.hold_o, bus.drain_o};
    ereq = {1'b1, 32'h200, 1'b1, 32'h100, 5'b11110, 5'b00000, 1'b1};
    checks++;
    if (egot !== ereq) $display("FAIL int_enter actual=%h required=%h", egot, ereq); else passed++;
    @(negedge clk); bus.int_req_i = 1'b0; #2;
    checks++;
    if ({bus.drain_o, bus.int_ack_o, bus.hold_o, bus.redirect_o} !== 8'b0)
      $display("FAIL int_back_idle actual=%b required=00000000", {bus.drain_o, bus.int_ack_o, bus.hold_o, bus.redirect_o});
    else passed++;
  endtask

  task automatic test_drain_interaction();
    int          ack_at = 0;
    logic [31:0] epc_seen = '0;
    logic [42:0] got;
    @(negedge clk); clr(); bus.int_req_i = 1'b1; bus.if_pc_i = 32'h300; #2;
    for (int c = 1; c <= 12 && ack_at == 0; c++) begin
      @(negedge clk);
      bus.br_taken_i = (c == 2); bus.br_target_i = 32'h40;
      bus.mem_busy_i = (c >= 3 && c <= 5);
      #2;
      got = {bus.redirect_o, bus.redirect_pc_o, bus.hold_o, bus.flush_o};
      if (c == 2) begin
        checks++;
        if (got !== {1'b1, 32'h40, 5'b00001, 5'b00110})
          $display("FAIL drain_branch actual=%h required=%h", got, {1'b1, 32'h40, 5'b00001, 5'b00110});
        else passed++;
      end
      if (c == 3) begin
        checks++;
        if (got !== {1'b0, 32'h0, 5'b01111, 5'b10000})
          $display("FAIL drain_mem_stall actual=%h required=%h", got, {1'b0, 32'h0, 5'b01111, 5'b10000});
        else passed++;
      end
      if (bus.int_ack_o === 1'b1) begin ack_at = c; epc_seen = bus.int_epc_o; end
    end
    checks++;
    if (ack_at != 8) $display("FAIL drain_enter_delay actual=%0d required=8", ack_at); else passed++;
    checks++;
    if (epc_seen !== 32'h40) $display("FAIL drain_epc actual=%h required=00000040", epc_seen); else passed++;
    @(negedge clk); clr(); #2;
  endtask

  task automatic test_clint_freeze();
    int          ack_at = 0;
    logic [10:0] got;
    @(negedge clk); clr(); bus.int_req_i = 1'b1; #2;
    for (int c = 1; c <= 14 && ack_at == 0; c++) begin
      @(negedge clk);
      bus.hold_flag_clint_i = (c >= 2 && c <= 6);
      #2;
      got = {bus.hold_o, bus.flush_o, bus.redirect_o};
      if (c == 2 || c == 6) begin
        checks++;
        if (got !== {5'b11111, 5'b00000, 1'b0})
          $display("FAIL clint_hold c=%0d actual=%b required=%b", c, got, {5'b11111, 5'b00000, 1'b0});
        else passed++;
      end
      if (bus.int_ack_o === 1'b1) ack_at = c;
    end
    checks++;
    if (ack_at != 10) $display("FAIL clint_enter_delay actual=%0d required=10", ack_at); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== '0) $display("FAIL reset_in_enter actual=%h required=0", observed()); else passed++;
    @(negedge clk); rst_n = 1'b1; #2;
    checks++;
    if ({bus.drain_o, bus.int_ack_o} !== 2'b00)
      $display("FAIL post_reset_idle actual=%b required=00", {bus.drain_o, bus.int_ack_o});
    else passed++;
    @(negedge clk); #2;
    checks++;
    if ({bus.drain_o, bus.hold_o} !== 6'b100001)
      $display("FAIL post_reset_resample actual=%b required=100001", {bus.drain_o, bus.hold_o});
    else passed++;
  endtask

  task automatic test_random();
    bit          req_hold = 1'b0;
    logic [OW-1:0] exp;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      bus.br_taken_i        = ($urandom_range(0, 3) == 0);
      bus.br_target_i       = $urandom();
      bus.load_use_i        = ($urandom_range(0, 5) == 0);
      bus.mc_busy_i         = ($urandom_range(0, 7) == 0);
      bus.mem_busy_i        = ($urandom_range(0, 7) == 0);
      bus.hold_flag_clint_i = ($urandom_range(0, 9) == 0);
      bus.int_target_i      = $urandom();
      bus.if_pc_i           = $urandom();
      if (!req_hold && $urandom_range(0, 7) == 0) req_hold = 1'b1;
      bus.int_req_i = req_hold;
      #2;
      exp = model_out();
      checks++;
      if (observed() !== exp) $display("FAIL random c=%0d actual=%h required=%h", c, observed(), exp);
      else passed++;
      if (bus.int_ack_o === 1'b1) req_hold = 1'b0;
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall_priority();
    test_interrupt();
    test_drain_interaction();
    test_clint_freeze();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
